// File: rtl/interrupt_controller.sv
// ============================================================================
// interrupt_controller : edge-detected, masked, fixed-priority interrupt source
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module interrupt_controller #(
  parameter int NSRC = 8,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NSRC-1:0] irq,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wd,
  output logic [NSRC-1:0] mask,
  output logic [NSRC-1:0] pending,
  output logic            intr,
  input  logic            inta,
  output logic [IDW-1:0]  int_id,
  output logic            in_service,
  input  logic            eoi
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NSRC-1:0] irq_prev_q, irq_prev_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic            intr_q, intr_d;
  logic [IDW-1:0]  int_id_q, int_id_d;
  logic            in_service_q, in_service_d;

  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_elig;
  logic [NSRC-1:0] w_ack_clr;
  logic [IDW-1:0]  w_win;

  always_comb begin
    w_rise    = irq & ~irq_prev_q;
    w_elig    = pending_q & ~mask_q;
    w_ack_clr = '0;
    w_win     = '0;
    // Descending scan so the lowest eligible index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = IDW'(i);
    end

    state_d      = state_q;
    intr_d       = intr_q;
    int_id_d     = int_id_q;
    in_service_d = in_service_q;
    irq_prev_d   = irq;
    mask_d       = mask_we ? mask_wd : mask_q;

    case (state_q)
      ST_IDLE: begin
        if (|w_elig) begin
          int_id_d = w_win;
          intr_d   = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (inta) begin
          w_ack_clr[int_id_q] = 1'b1;
          intr_d              = 1'b0;
          in_service_d        = 1'b1;
          state_d             = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        intr_d       = 1'b0;
        in_service_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase

    // A fresh edge on the source being acknowledged survives the clear.
    pending_d = (pending_q & ~w_ack_clr) | w_rise;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      irq_prev_q   <= '0;
      mask_q       <= '1;
      pending_q    <= '0;
      intr_q       <= 1'b0;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq_prev_d;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      intr_q       <= intr_d;
      int_id_q     <= int_id_d;
      in_service_q <= in_service_d;
    end
  end

  assign mask       = mask_q;
  assign pending    = pending_q;
  assign intr       = intr_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;

endmodule

`default_nettype wire
